piso_tx: RTL

- Parallel-in, serial-out transmitter. Sits directly upstream of the serial-in/parallel-out receiver and drives its serial data and start inputs.
- Captures a 7-bit word (a dice value) through a valid/ready handshake. Shifts the word out LSB-first, one bit per CYCLES_PER_BIT clocks.
- Pulses a start strobe aligned with the first bit, and a done strobe after the last.

---
 rtl/dice_serial_pkg.sv | 12 +
 rtl/piso_tx_bit_timer.sv | 32 +++
 rtl/piso_tx.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dice_serial_pkg.sv
// Shared definitions for the dice serial link (piso_tx transmitter and its receiver).
// FSM encoding and default link parameters live here so both ends stay in step.
package dice_serial_pkg;

  localparam int DEFAULT_CYCLES_PER_BIT = 10;
  localparam int DEFAULT_DATA_WIDTH     = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/piso_tx_bit_timer.sv
// bit_timer: free-running bit-period counter, 0..CYCLES_PER_BIT-1, wrapping to 0.
// tick marks the last cycle of a bit period; clear restarts the period.
module bit_timer
  import dice_serial_pkg::*;
#(
  parameter int CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [7:0] TERM = 8'(CYCLES_PER_BIT - 1);

  logic [7:0] count;

  // With CYCLES_PER_BIT == 1 the count sits at 0 == TERM, so every cycle ticks.
  assign tick = (count == TERM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= tick ? 8'd0 : count + 8'd1;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, LSB first, CYCLES_PER_BIT clocks per bit.
// Optional even-parity bit after the data bits when PISO_TX_PARITY_EN is defined.
module piso_tx
  import dice_serial_pkg::*;
#(
  parameter int CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_serial,
  output logic                  o_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [1:0]            o_state
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
`ifdef PISO_TX_PARITY_EN
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH);
`else
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
`endif

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [BW-1:0]         bit_cnt;
  logic                  tick;
  logic                  handshake;
  logic                  last_bit;
`ifdef PISO_TX_PARITY_EN
  logic                  parity_q;
`endif

  // Handshake: a word transfers on any rising edge where i_valid && o_ready;
  // o_ready is high only in IDLE, and i_data must be stable while i_valid waits.
  assign handshake  = i_valid && o_ready;
  assign shift_next = shift_reg >> 1;
  assign last_bit   = (bit_cnt == LAST_BIT);
  assign o_state    = state;

  bit_timer #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .clear (handshake),
    .enable(state == ST_SHIFT),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      o_ready   <= 1'b1;
      o_serial  <= 1'b0;
      o_start   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      o_start <= 1'b0;
      o_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            state     <= ST_SHIFT;
            shift_reg <= i_data;
            bit_cnt   <= '0;
            o_serial  <= i_data[0];
            o_start   <= 1'b1;
            o_busy    <= 1'b1;
            o_ready   <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            parity_q  <= ^i_data;
`endif
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (last_bit) begin
              state    <= ST_DONE;
              bit_cnt  <= '0;
              o_serial <= 1'b0;
              o_busy   <= 1'b0;
              o_done   <= 1'b1;
            end else begin
              shift_reg <= shift_next;
              bit_cnt   <= bit_cnt + BW'(1);
`ifdef PISO_TX_PARITY_EN
              o_serial  <= (bit_cnt == DATA_LAST) ? parity_q : shift_next[0];
`else
              o_serial  <= shift_next[0];
`endif
            end
          end
        end
        ST_DONE: begin
          // Single cycle with ready low guarantees a gap before the next o_start.
          state   <= ST_IDLE;
          o_ready <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          o_ready  <= 1'b1;
          o_busy   <= 1'b0;
          o_serial <= 1'b0;
        end
      endcase
    end
  end

endmodule
